// File: rtl/ifu_fetch_aligner_pkg.sv
// Shared types and constants for the fetch aligner and its halfword ring buffer.
package ifu_fetch_aligner_pkg;

    localparam int unsigned FetchBytesDefault = 4;

    // One queue entry: a 16-bit parcel plus the {page, access} fault tag of its block.
    localparam int unsigned EntryW = 18;

    typedef struct packed {
        logic [1:0]  fault;
        logic [15:0] data;
    } hw_entry_t;

    // Any parcel whose two low bits are not 2'b11 starts a compressed instruction.
    function automatic logic is_rvc(input logic [15:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/ifu_fetch_aligner_hw_ring_fifo.sv
// Halfword ring buffer: up to PUSH_W entries pushed and up to two popped per cycle,
// with the head and head+1 entries visible for instruction assembly.
module ifu_fetch_aligner_hw_ring_fifo
    import ifu_fetch_aligner_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PUSH_W = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic [$clog2(DEPTH):0]     push_n_i,
    input  logic [PUSH_W*EntryW-1:0]   push_data_i,
    input  logic [1:0]                 pop_n_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [15:0]                head_data_o,
    output logic [1:0]                 head_fault_o,
    output logic [15:0]                next_data_o,
    output logic [1:0]                 next_fault_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    hw_entry_t       mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    // Storage write: push slot k lands at wr_ptr + k; pointer arithmetic wraps mod DEPTH.
    always_ff @(posedge clk) begin
        for (int k = 0; k < PUSH_W; k++) begin
            if (!flush_i && (CntW'(k) < push_n_i)) begin
                mem_q[wr_ptr_q + PtrW'(k)] <= hw_entry_t'(push_data_i[k*EntryW +: EntryW]);
            end
        end
    end

    // Next pointers and occupancy; flush empties the ring.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(push_n_i);
        rd_ptr_d = rd_ptr_q + PtrW'(pop_n_i);
        count_d  = count_q + push_n_i - CntW'(pop_n_i);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o      = count_q;
    assign head_data_o  = mem_q[rd_ptr_q].data;
    assign head_fault_o = mem_q[rd_ptr_q].fault;
    assign next_data_o  = mem_q[rd_ptr_q + PtrW'(1)].data;
    assign next_fault_o = mem_q[rd_ptr_q + PtrW'(1)].fault;

endmodule

// File: rtl/ifu_fetch_aligner.sv
// Fetch aligner: queues fetch blocks as halfwords and re-forms mixed 16/32-bit
// instructions (including block-straddling ones), one per cycle, with PC and fault.
module ifu_fetch_aligner
    import ifu_fetch_aligner_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned FETCH_BYTES = FetchBytesDefault,
    parameter int unsigned DEPTH       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic [XLEN-1:0]          redirect_pc_i,
    input  logic                     fetch_valid_i,
    output logic                     fetch_ready_o,
    input  logic [FETCH_BYTES*8-1:0] fetch_data_i,
    input  logic [XLEN-1:0]          fetch_pc_i,
    input  logic [1:0]               fetch_fault_i,
    output logic                     inst_valid_o,
    input  logic                     inst_ready_i,
    output logic [XLEN-1:0]          inst_pc_o,
    output logic [31:0]              inst_data_o,
    output logic                     inst_is_c_o,
    output logic [1:0]               inst_fault_o
);

    localparam int unsigned FHW  = FETCH_BYTES / 2;
    localparam int unsigned OffW = $clog2(FHW);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
    localparam logic [CntW-1:0] FhwC   = CntW'(FHW);

    logic [CntW-1:0]       count;
    logic [15:0]           hw0, hw1;
    logic [1:0]            f0, f1;
    logic [CntW-1:0]       push_n;
    logic [FHW*EntryW-1:0] push_data;
    logic [1:0]            n_deq, pop_n;
    logic                  enq;
    logic [OffW-1:0]       off;
    logic                  fault_lock_q, fault_lock_d;
    logic [XLEN-1:0]       head_pc_q, head_pc_d;
    logic                  unused_pc_bits;

    // Only the in-block halfword offset of the fetch PC matters here.
    assign off            = fetch_pc_i[OffW:1];
    assign unused_pc_bits = ^{fetch_pc_i[XLEN-1:OffW+1], fetch_pc_i[0]};

    // Registered-state-only ready: room for a whole block and no fault pending.
    assign fetch_ready_o = !fault_lock_q && ((DepthC - count) >= FhwC);
    assign enq           = fetch_valid_i && fetch_ready_o && !flush_i;

    // Enqueue packing: halfwords off..FHW-1 in ascending order, or one tagged entry on fault.
    always_comb begin
        push_n    = '0;
        push_data = '0;
        if (enq) begin
            if (fetch_fault_i != 2'b00) begin
                push_n                = CntW'(1);
                push_data[EntryW-1:0] = {fetch_fault_i, 16'h0000};
            end else begin
                push_n = FhwC - CntW'(off);
                for (int k = 0; k < FHW; k++) begin
                    if (k + int'(off) < FHW) begin
                        push_data[k*EntryW +: EntryW] =
                            {2'b00, fetch_data_i[(k + int'(off))*16 +: 16]};
                    end
                end
            end
        end
    end

    // Instruction assembly from the head of the queue.
    // A faulted entry is always the last one queued (fault_lock), so it stands alone.
    always_comb begin
        inst_valid_o = 1'b0;
        inst_data_o  = '0;
        inst_is_c_o  = 1'b0;
        inst_fault_o = 2'b00;
        n_deq        = 2'd0;
        if (count != '0) begin
            if (f0 != 2'b00) begin
                inst_valid_o = 1'b1;
                inst_fault_o = f0;
                n_deq        = 2'd1;
            end else if (is_rvc(hw0)) begin
                inst_valid_o = 1'b1;
                inst_data_o  = {16'h0000, hw0};
                inst_is_c_o  = 1'b1;
                n_deq        = 2'd1;
            end else if (count >= CntW'(2)) begin
                inst_valid_o = 1'b1;
                inst_data_o  = {hw1, hw0};
                inst_fault_o = f0 | f1;
                n_deq        = 2'd2;
            end
        end
    end

    assign pop_n     = (inst_valid_o && inst_ready_i && !flush_i) ? n_deq : 2'd0;
    assign inst_pc_o = head_pc_q;

    // Head PC and fault lock next state; flush overrides everything.
    always_comb begin
        head_pc_d    = head_pc_q;
        fault_lock_d = fault_lock_q;
        if (flush_i) begin
            head_pc_d    = redirect_pc_i;
            fault_lock_d = 1'b0;
        end else begin
            if (pop_n != 2'd0) begin
                head_pc_d = head_pc_q + ((pop_n == 2'd1) ? XLEN'(2) : XLEN'(4));
            end
            if (enq && (fetch_fault_i != 2'b00)) begin
                fault_lock_d = 1'b1;
            end
        end
    end

    // Head PC and fault lock registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_pc_q    <= '0;
            fault_lock_q <= 1'b0;
        end else begin
            head_pc_q    <= head_pc_d;
            fault_lock_q <= fault_lock_d;
        end
    end

    ifu_fetch_aligner_hw_ring_fifo #(
        .DEPTH  (DEPTH),
        .PUSH_W (FHW)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush_i),
        .push_n_i     (push_n),
        .push_data_i  (push_data),
        .pop_n_i      (pop_n),
        .count_o      (count),
        .head_data_o  (hw0),
        .head_fault_o (f0),
        .next_data_o  (hw1),
        .next_fault_o (f1)
    );

endmodule

// File: tb/tb_ifu_fetch_aligner.sv
// Bench for ifu_fetch_aligner: directed table, hand sequences, then random traffic
// checked against a halfword-queue reference model.
module tb_ifu_fetch_aligner;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned FB    = 4;
    localparam int unsigned FHW   = FB / 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        fetch_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic [31:0] fetch_data_i = '0;
    logic [31:0] fetch_pc_i = '0;
    logic [1:0]  fetch_fault_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_pc_o;
    logic [31:0] inst_data_o;
    logic        inst_is_c_o;
    logic [1:0]  inst_fault_o;

    logic        e8_flush = 1'b0;
    logic [31:0] e8_redir = '0;
    logic        e8_fv = 1'b0;
    logic        e8_ready;
    logic [63:0] e8_data = '0;
    logic [31:0] e8_pc = '0;
    logic        e8_valid;
    logic [31:0] e8_ipc;
    logic [31:0] e8_idata;
    logic        e8_is_c;
    logic [1:0]  e8_ifault;

    always #5 clk = ~clk;

    ifu_fetch_aligner #(.XLEN(32), .FETCH_BYTES(FB), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .redirect_pc_i(redirect_pc_i),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
        .fetch_data_i(fetch_data_i), .fetch_pc_i(fetch_pc_i), .fetch_fault_i(fetch_fault_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i), .inst_pc_o(inst_pc_o),
        .inst_data_o(inst_data_o), .inst_is_c_o(inst_is_c_o), .inst_fault_o(inst_fault_o)
    );

    ifu_fetch_aligner #(.XLEN(32), .FETCH_BYTES(8), .DEPTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .flush_i(e8_flush), .redirect_pc_i(e8_redir),
        .fetch_valid_i(e8_fv), .fetch_ready_o(e8_ready),
        .fetch_data_i(e8_data), .fetch_pc_i(e8_pc), .fetch_fault_i(2'b00),
        .inst_valid_o(e8_valid), .inst_ready_i(1'b1), .inst_pc_o(e8_ipc),
        .inst_data_o(e8_idata), .inst_is_c_o(e8_is_c), .inst_fault_o(e8_ifault)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a queue of {fault, halfword} parcels in program order.
    logic [17:0] mq [$];
    logic [31:0] m_pc = '0;
    bit          m_lock = 1'b0;
    logic [31:0] tail_pc = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_ready();
        return !m_lock && ((int'(DEPTH) - mq.size()) >= int'(FHW));
    endfunction

    task automatic m_reset();
        mq.delete();
        m_pc    = '0;
        m_lock  = 1'b0;
        tail_pc = '0;
    endtask

    // Next instruction per the ISA length rule; a fault parcel is an instruction of its own.
    task automatic m_out(output bit v, output logic [31:0] d, output bit c,
                         output logic [1:0] f, output int len);
        v = 0; d = '0; c = 0; f = 2'b00; len = 0;
        if (mq.size() == 0) return;
        if (mq[0][17:16] != 2'b00) len = 1;
        else if (mq[0][1:0] != 2'b11) len = 1;
        else len = 2;
        if (mq.size() < len) return;
        v = 1;
        for (int i = 0; i < len; i++) f = f | mq[i][17:16];
        if (f != 2'b00 && len == 1) d = '0;
        else if (len == 1) begin d = {16'h0, mq[0][15:0]}; c = 1; end
        else d = {mq[1][15:0], mq[0][15:0]};
    endtask

    task automatic cmp_model();
        bit v; logic [31:0] d; bit c; logic [1:0] f; int len;
        m_out(v, d, c, f, len);
        chk("inst_valid", inst_valid_o, v);
        chk("inst_pc", inst_pc_o, m_pc);
        chk("fetch_ready", fetch_ready_o, m_ready());
        if (v) begin
            chk("inst_data", inst_data_o, d);
            chk("inst_is_c", inst_is_c_o, c);
            chk("inst_fault", inst_fault_o, f);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        cmp_model();
    endtask

    // Clock edge: apply the handshakes the model sees to the model state.
    task automatic advance();
        bit v; logic [31:0] d; bit c; logic [1:0] f; int len; bit acc;
        m_out(v, d, c, f, len);
        acc = fetch_valid_i && m_ready() && !flush_i;
        @(posedge clk);
        if (!rst_n) begin
            m_reset();
        end else if (flush_i) begin
            mq.delete();
            m_lock  = 1'b0;
            m_pc    = redirect_pc_i;
            tail_pc = redirect_pc_i;
        end else begin
            if (v && inst_ready_i) begin
                repeat (len) void'(mq.pop_front());
                m_pc = m_pc + 32'(2 * len);
            end
            if (acc) begin
                if (fetch_fault_i != 2'b00) begin
                    mq.push_back({fetch_fault_i, 16'h0000});
                    m_lock = 1'b1;
                end else begin
                    for (int h = int'(fetch_pc_i[1]); h < int'(FHW); h++)
                        mq.push_back({2'b00, fetch_data_i[h*16 +: 16]});
                end
                tail_pc = {fetch_pc_i[31:2], 2'b00} + 32'(FB);
            end
        end
        #1;
    endtask

    task automatic set_idle();
        flush_i = 0; fetch_valid_i = 0; fetch_fault_i = 2'b00; fetch_data_i = '0;
    endtask

    function automatic logic [15:0] rand_hw();
        logic [15:0] hw;
        hw = 16'($urandom());
        if ($urandom_range(0, 1) == 1) hw[1:0] = 2'b11;
        else hw[1:0] = 2'($urandom_range(0, 2));
        return hw;
    endfunction

    typedef struct {
        logic        flush;
        logic [31:0] redir;
        logic        fv;
        logic [31:0] fdata;
        logic [31:0] fpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_data;
        logic        e_c;
        logic        e_ready;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // Expected outputs are those visible during the same cycle the inputs are driven.
        tbl[0]  = '{1, 32'h80000000, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0,        0, 1};
        tbl[1]  = '{0, 32'h0,        1, 32'h00A00093, 32'h80000000, 0, 32'h80000000, 32'h0,        0, 1};
        tbl[2]  = '{0, 32'h0,        1, 32'h00410113, 32'h80000004, 1, 32'h80000000, 32'h00A00093, 0, 1};
        tbl[3]  = '{0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h80000004, 32'h00410113, 0, 1};
        tbl[4]  = '{0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h80000008, 32'h0,        0, 1};
        tbl[5]  = '{1, 32'h80000000, 0, 32'h0,        32'h0,        0, 32'h80000008, 32'h0,        0, 1};
        tbl[6]  = '{0, 32'h0,        1, 32'h00934505, 32'h80000000, 0, 32'h80000000, 32'h0,        0, 1};
        tbl[7]  = '{0, 32'h0,        1, 32'hFFFF00A0, 32'h80000004, 1, 32'h80000000, 32'h00004505, 1, 1};
        tbl[8]  = '{0, 32'h0,        0, 32'h0,        32'h0,        1, 32'h80000002, 32'h00A00093, 0, 1};
        tbl[9]  = '{0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h80000006, 32'h0,        0, 1};
        tbl[10] = '{0, 32'h0,        0, 32'h0,        32'h0,        0, 32'h80000006, 32'h0,        0, 1};

        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        m_reset();

        // Reset state.
        @(negedge clk);
        chk("rst_valid", inst_valid_o, 0);
        chk("rst_ready", fetch_ready_o, 1);
        chk("rst_pc", inst_pc_o, 0);
        chk("rst_data", inst_data_o, 0);
        chk("rst_is_c", inst_is_c_o, 0);
        chk("rst_fault", inst_fault_o, 0);
        @(posedge clk); #1;

        // T1/T2: aligned 32-bit pair, then RVC + straddling 32-bit + waiting half.
        inst_ready_i = 1;
        for (int i = 0; i < 11; i++) begin
            flush_i = tbl[i].flush; redirect_pc_i = tbl[i].redir;
            fetch_valid_i = tbl[i].fv; fetch_data_i = tbl[i].fdata;
            fetch_pc_i = tbl[i].fpc; fetch_fault_i = 2'b00;
            sample();
            chk($sformatf("tbl%0d_valid", i), inst_valid_o, tbl[i].e_valid);
            chk($sformatf("tbl%0d_pc", i), inst_pc_o, tbl[i].e_pc);
            chk($sformatf("tbl%0d_ready", i), fetch_ready_o, tbl[i].e_ready);
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_data", i), inst_data_o, tbl[i].e_data);
                chk($sformatf("tbl%0d_is_c", i), inst_is_c_o, tbl[i].e_c);
                chk($sformatf("tbl%0d_fault", i), inst_fault_o, 0);
            end
            advance();
        end
        set_idle();

        // T3 (8-byte blocks): redirect to the last halfword; only bits [63:48] are queued.
        e8_flush = 1; e8_redir = 32'h80000006;
        sample(); advance();
        e8_flush = 0; e8_fv = 1; e8_pc = 32'h80000006; e8_data = 64'h4501_0001_0000_0000;
        sample();
        chk("t3_valid_before", e8_valid, 0);
        chk("t3_ready", e8_ready, 1);
        advance();
        e8_fv = 0;
        sample();
        chk("t3_valid", e8_valid, 1);
        chk("t3_pc", e8_ipc, 32'h80000006);
        chk("t3_data", e8_idata, 32'h00004501);
        chk("t3_is_c", e8_is_c, 1);
        advance();
        sample();
        chk("t3_drained", e8_valid, 0);
        chk("t3_pc_next", e8_ipc, 32'h80000008);
        advance();

        // T4: backpressure fills the queue with four 32-bit blocks.
        flush_i = 1; redirect_pc_i = 32'h00001000; inst_ready_i = 0;
        sample(); advance();
        flush_i = 0;
        for (int i = 0; i < 5; i++) begin
            fetch_valid_i = 1; fetch_pc_i = tail_pc; fetch_data_i = $urandom() | 32'h3;
            sample();
            if (i == 4) chk("t4_full_ready", fetch_ready_o, 0);
            advance();
        end
        inst_ready_i = 1;
        sample(); advance();
        inst_ready_i = 0;
        sample();
        chk("t4_ready_back", fetch_ready_o, 1);
        advance();
        fetch_valid_i = 0; inst_ready_i = 1;
        repeat (6) begin sample(); advance(); end

        // T5: 32-bit low half queued, then a page-fault block completes it.
        flush_i = 1; redirect_pc_i = 32'h00002002;
        sample(); advance();
        flush_i = 0; fetch_valid_i = 1; fetch_pc_i = 32'h00002002; fetch_data_i = 32'h0093_1234;
        sample(); advance();
        fetch_pc_i = 32'h00002004; fetch_fault_i = 2'b10; fetch_data_i = 32'hDEADBEEF;
        sample();
        chk("t5_wait_half", inst_valid_o, 0);
        advance();
        fetch_valid_i = 0; fetch_fault_i = 2'b00;
        sample();
        chk("t5_valid", inst_valid_o, 1);
        chk("t5_data", inst_data_o, 32'h00000093);
        chk("t5_fault", inst_fault_o, 2'b10);
        chk("t5_pc", inst_pc_o, 32'h00002002);
        chk("t5_locked", fetch_ready_o, 0);
        advance();
        fetch_valid_i = 1; fetch_pc_i = 32'h00002008; fetch_data_i = 32'h45054505;
        repeat (3) begin
            sample();
            chk("t5_still_locked", fetch_ready_o, 0);
            advance();
        end
        fetch_valid_i = 0; flush_i = 1; redirect_pc_i = 32'h00003000;
        sample(); advance();
        flush_i = 0;
        sample();
        chk("t5_unlocked", fetch_ready_o, 1);
        chk("t5_flush_pc", inst_pc_o, 32'h00003000);
        advance();

        // T6: flush coinciding with enqueue and dequeue, then an async reset mid-stream.
        flush_i = 1; redirect_pc_i = 32'h00004000; inst_ready_i = 0;
        sample(); advance();
        flush_i = 0; fetch_valid_i = 1;
        repeat (2) begin
            fetch_pc_i = tail_pc; fetch_data_i = 32'h45054505;
            sample(); advance();
        end
        flush_i = 1; redirect_pc_i = 32'h00005000; inst_ready_i = 1;
        fetch_pc_i = tail_pc; fetch_data_i = 32'h00010001;
        sample();
        chk("t6_valid_in_flush", inst_valid_o, 1);
        advance();
        flush_i = 0; fetch_valid_i = 0;
        sample();
        chk("t6_flush_empty", inst_valid_o, 0);
        chk("t6_flush_pc", inst_pc_o, 32'h00005000);
        chk("t6_flush_ready", fetch_ready_o, 1);
        advance();
        fetch_valid_i = 1; fetch_pc_i = 32'h00005000; fetch_data_i = 32'h45054505;
        inst_ready_i = 0;
        sample(); advance();
        fetch_valid_i = 0;
        #1 rst_n = 0;
        m_reset();
        #1;
        chk("t6_rst_valid", inst_valid_o, 0);
        chk("t6_rst_pc", inst_pc_o, 0);
        chk("t6_rst_ready", fetch_ready_o, 1);
        #1 rst_n = 1;
        sample(); advance();

        // Random traffic against the model; blocks always continue from the tail PC.
        for (int n = 0; n < 3000; n++) begin
            flush_i = ($urandom_range(0, 31) == 0);
            redirect_pc_i = $urandom() & 32'hFFFF_FFFE;
            fetch_valid_i = ($urandom_range(0, 9) < 6);
            fetch_pc_i = tail_pc;
            fetch_data_i = {rand_hw(), rand_hw()};
            fetch_fault_i = ($urandom_range(0, 49) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            inst_ready_i = ($urandom_range(0, 9) < 7);
            sample();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
